mem_port_arbiter: RTL and testbench

Two-requester arbiter sharing a single data-memory port between two cache controllers, for example an instruction cache and a data cache. Each cache connects its memory-side bus unchanged: read, write, block address, block write data, block read data, busywait, read-done and write-done. Only one cache owns the memory per transaction. Grants alternate round-robin on contention, and a watchdog counter aborts hung transactions. The block sits between the cache instances and the memory model.

---
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one block-memory port between two cache controllers,
// with a per-transaction watchdog that aborts hung memory accesses.
module mem_port_arbiter #(
    parameter int ADDR_W  = 28,
    parameter int DATA_W  = 128,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              c0_m_read_i,
    input  logic              c0_m_wr_i,
    input  logic [ADDR_W-1:0] c0_m_address_i,
    input  logic [DATA_W-1:0] c0_m_write_data_i,
    output logic [DATA_W-1:0] c0_m_read_data_o,
    output logic              c0_m_busywait_o,
    output logic              c0_m_read_done_o,
    output logic              c0_m_write_done_o,
    input  logic              c1_m_read_i,
    input  logic              c1_m_wr_i,
    input  logic [ADDR_W-1:0] c1_m_address_i,
    input  logic [DATA_W-1:0] c1_m_write_data_i,
    output logic [DATA_W-1:0] c1_m_read_data_o,
    output logic              c1_m_busywait_o,
    output logic              c1_m_read_done_o,
    output logic              c1_m_write_done_o,
    output logic              m_read_o,
    output logic              m_wr_o,
    output logic [ADDR_W-1:0] m_address_o,
    output logic [DATA_W-1:0] m_write_data_o,
    input  logic [DATA_W-1:0] m_read_data_i,
    input  logic              m_busywait_i,
    input  logic              m_read_done_i,
    input  logic              m_write_done_i,
    output logic [1:0]        grant_o,
    output logic              timeout_err_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_GRANT   = 2'b01,
        ST_RELEASE = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] WD_LAST_C = CNT_W'(TIMEOUT - 1);

    state_t             state_r, state_nxt_s;
    logic               owner_r, owner_nxt_s;
    logic               last_r, last_nxt_s;
    logic [CNT_W-1:0]   wd_cnt_r, wd_cnt_nxt_s;
    logic               timeout_err_r, timeout_err_nxt_s;

    logic               req0_s, req1_s;
    logic               own_rd_s, own_wr_s, own_req_s;
    logic [ADDR_W-1:0]  own_addr_s;
    logic [DATA_W-1:0]  own_wdata_s;
    logic               in_grant_s, serve0_s, serve1_s, mem_done_s;

    assign req0_s     = c0_m_read_i | c0_m_wr_i;
    assign req1_s     = c1_m_read_i | c1_m_wr_i;
    assign in_grant_s = (state_r == ST_GRANT);
    assign serve0_s   = in_grant_s & ~owner_r;
    assign serve1_s   = in_grant_s & owner_r;
    assign mem_done_s = (m_read_done_i | m_write_done_i) & ~m_busywait_i;

    // Select the owner's bus; a simultaneous read and write is forwarded as a write only.
    always_comb begin
        own_rd_s    = 1'b0;
        own_wr_s    = 1'b0;
        own_addr_s  = c0_m_address_i;
        own_wdata_s = c0_m_write_data_i;
        if (owner_r) begin
            own_rd_s    = c1_m_read_i & ~c1_m_wr_i;
            own_wr_s    = c1_m_wr_i;
            own_addr_s  = c1_m_address_i;
            own_wdata_s = c1_m_write_data_i;
        end else begin
            own_rd_s    = c0_m_read_i & ~c0_m_wr_i;
            own_wr_s    = c0_m_wr_i;
            own_addr_s  = c0_m_address_i;
            own_wdata_s = c0_m_write_data_i;
        end
    end
    assign own_req_s = own_rd_s | own_wr_s;

    assign m_read_o       = in_grant_s & own_rd_s;
    assign m_wr_o         = in_grant_s & own_wr_s;
    assign m_address_o    = own_addr_s;
    assign m_write_data_o = own_wdata_s;

    // An unserved port sees its own request reflected as busywait, which stalls it.
    assign c0_m_busywait_o   = serve0_s ? m_busywait_i : req0_s;
    assign c1_m_busywait_o   = serve1_s ? m_busywait_i : req1_s;
    assign c0_m_read_done_o  = serve0_s & m_read_done_i;
    assign c0_m_write_done_o = serve0_s & m_write_done_i;
    assign c1_m_read_done_o  = serve1_s & m_read_done_i;
    assign c1_m_write_done_o = serve1_s & m_write_done_i;
    assign c0_m_read_data_o  = m_read_data_i;
    assign c1_m_read_data_o  = m_read_data_i;

    assign grant_o       = {serve1_s, serve0_s};
    assign timeout_err_o = timeout_err_r;

    // Next-state, ownership and watchdog logic.
    always_comb begin
        state_nxt_s       = state_r;
        owner_nxt_s       = owner_r;
        last_nxt_s        = last_r;
        wd_cnt_nxt_s      = wd_cnt_r;
        timeout_err_nxt_s = timeout_err_r;
        case (state_r)
            ST_IDLE: begin
                if (req0_s | req1_s) begin
                    state_nxt_s  = ST_GRANT;
                    wd_cnt_nxt_s = {CNT_W{1'b0}};
                    if (req0_s & req1_s) begin
                        owner_nxt_s = ~last_r;
                    end else begin
                        owner_nxt_s = req1_s;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                wd_cnt_nxt_s = wd_cnt_r + CNT_W'(1);
                if (mem_done_s) begin
                    state_nxt_s = ST_RELEASE;
                    last_nxt_s  = owner_r;
                end else if (!own_req_s) begin
                    state_nxt_s = ST_RELEASE;
                    last_nxt_s  = owner_r;
                end else if (wd_cnt_r == WD_LAST_C) begin
                    state_nxt_s       = ST_RELEASE;
                    last_nxt_s        = owner_r;
                    timeout_err_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_GRANT;
                end
            end
            ST_RELEASE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register; last resets to 1 so port 0 wins the first tie.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_r       <= ST_IDLE;
            owner_r       <= 1'b0;
            last_r        <= 1'b1;
            wd_cnt_r      <= {CNT_W{1'b0}};
            timeout_err_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            owner_r       <= owner_nxt_s;
            last_r        <= last_nxt_s;
            wd_cnt_r      <= wd_cnt_nxt_s;
            timeout_err_r <= timeout_err_nxt_s;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected memory transactions are queued
// as cache requests are driven and checked when the arbiter issues them.
module tb_mem_port_arbiter;

    localparam int ADDR_W  = 28;
    localparam int DATA_W  = 128;
    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 8;

    typedef struct packed {
        logic [1:0]        grant;
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } txn_t;

    logic              clk_i = 1'b0;
    logic              reset_ni;
    logic              c0_m_read_i, c0_m_wr_i, c1_m_read_i, c1_m_wr_i;
    logic [ADDR_W-1:0] c0_m_address_i, c1_m_address_i;
    logic [DATA_W-1:0] c0_m_write_data_i, c1_m_write_data_i;
    logic [DATA_W-1:0] c0_m_read_data_o, c1_m_read_data_o;
    logic              c0_m_busywait_o, c0_m_read_done_o, c0_m_write_done_o;
    logic              c1_m_busywait_o, c1_m_read_done_o, c1_m_write_done_o;
    logic              m_read_o, m_wr_o;
    logic [ADDR_W-1:0] m_address_o;
    logic [DATA_W-1:0] m_write_data_o, m_read_data_i;
    logic              m_busywait_i, m_read_done_i, m_write_done_i;
    logic [1:0]        grant_o;
    logic              timeout_err_o;

    int   tests = 0;
    int   fails = 0;
    txn_t exp_q[$];

    logic [DATA_W-1:0] pat_a;
    logic [DATA_W-1:0] pat_b;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .c0_m_read_i(c0_m_read_i), .c0_m_wr_i(c0_m_wr_i), .c0_m_address_i(c0_m_address_i),
        .c0_m_write_data_i(c0_m_write_data_i), .c0_m_read_data_o(c0_m_read_data_o),
        .c0_m_busywait_o(c0_m_busywait_o), .c0_m_read_done_o(c0_m_read_done_o),
        .c0_m_write_done_o(c0_m_write_done_o),
        .c1_m_read_i(c1_m_read_i), .c1_m_wr_i(c1_m_wr_i), .c1_m_address_i(c1_m_address_i),
        .c1_m_write_data_i(c1_m_write_data_i), .c1_m_read_data_o(c1_m_read_data_o),
        .c1_m_busywait_o(c1_m_busywait_o), .c1_m_read_done_o(c1_m_read_done_o),
        .c1_m_write_done_o(c1_m_write_done_o),
        .m_read_o(m_read_o), .m_wr_o(m_wr_o), .m_address_o(m_address_o),
        .m_write_data_o(m_write_data_o), .m_read_data_i(m_read_data_i),
        .m_busywait_i(m_busywait_i), .m_read_done_i(m_read_done_i),
        .m_write_done_i(m_write_done_i), .grant_o(grant_o), .timeout_err_o(timeout_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic push_exp(input logic [1:0] g, input logic rd, input logic wr,
                            input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        txn_t t;
        t.grant = g; t.rd = rd; t.wr = wr; t.addr = a; t.wdata = d;
        exp_q.push_back(t);
    endtask

    task automatic apply_reset();
        reset_ni = 1'b0;
        @(posedge clk_i); #1;
        reset_ni = 1'b1;
    endtask

    // Waits for the arbiter to issue a memory request and checks it against the queue head.
    task automatic wait_grant(output bit ok, output txn_t e);
        logic other_req;
        ok = 1'b0;
        e  = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (m_read_o | m_wr_o) begin
                ok = 1'b1;
                break;
            end
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL grant_wait: no memory request within 20 cycles");
            return;
        end
        if (exp_q.size() == 0) begin
            fails++; ok = 1'b0;
            $display("FAIL scoreboard_empty: unexpected request grant=%b", grant_o);
            return;
        end
        e = exp_q.pop_front();
        tests++;
        if (grant_o !== e.grant) begin
            fails++; $display("FAIL grant_owner: got %b expected %b", grant_o, e.grant);
        end
        tests++;
        if ({m_read_o, m_wr_o} !== {e.rd, e.wr}) begin
            fails++; $display("FAIL mem_rd_wr: got %b expected %b", {m_read_o, m_wr_o}, {e.rd, e.wr});
        end
        tests++;
        if (m_address_o !== e.addr) begin
            fails++; $display("FAIL mem_addr: got %h expected %h", m_address_o, e.addr);
        end
        if (e.wr) begin
            tests++;
            if (m_write_data_o !== e.wdata) begin
                fails++; $display("FAIL mem_wdata: got %h expected %h", m_write_data_o, e.wdata);
            end
        end
        other_req = e.grant[0] ? (c1_m_read_i | c1_m_wr_i) : (c0_m_read_i | c0_m_wr_i);
        tests++;
        if ((e.grant[0] ? c1_m_busywait_o : c0_m_busywait_o) !== other_req) begin
            fails++; $display("FAIL nonowner_busy: got %b expected %b",
                              e.grant[0] ? c1_m_busywait_o : c0_m_busywait_o, other_req);
        end
    endtask

    // Memory model: busy for lat cycles, then one done pulse; the owner drops its request after.
    task automatic respond(input txn_t e, input int lat, input logic [DATA_W-1:0] rdata);
        logic own1;
        own1 = e.grant[1];
        m_busywait_i = 1'b1;
        #1;
        tests++;
        if ((own1 ? c1_m_busywait_o : c0_m_busywait_o) !== 1'b1) begin
            fails++; $display("FAIL owner_busy: got 0 expected 1");
        end
        repeat (lat) @(posedge clk_i);
        #1;
        m_busywait_i  = 1'b0;
        m_read_data_i = rdata;
        if (e.wr) m_write_done_i = 1'b1;
        else      m_read_done_i  = 1'b1;
        @(negedge clk_i);
        tests++;
        if ({c1_m_read_done_o, c1_m_write_done_o, c0_m_read_done_o, c0_m_write_done_o} !==
            (own1 ? {~e.wr, e.wr, 2'b00} : {2'b00, ~e.wr, e.wr})) begin
            fails++; $display("FAIL done_route: got %b expected %b",
                {c1_m_read_done_o, c1_m_write_done_o, c0_m_read_done_o, c0_m_write_done_o},
                own1 ? {~e.wr, e.wr, 2'b00} : {2'b00, ~e.wr, e.wr});
        end
        if (!e.wr) begin
            tests++;
            if ((own1 ? c1_m_read_data_o : c0_m_read_data_o) !== rdata) begin
                fails++; $display("FAIL read_data: got %h expected %h",
                                  own1 ? c1_m_read_data_o : c0_m_read_data_o, rdata);
            end
        end
        @(posedge clk_i); #1;
        m_read_done_i  = 1'b0;
        m_write_done_i = 1'b0;
        if (own1) begin c1_m_read_i = 1'b0; c1_m_wr_i = 1'b0; end
        else      begin c0_m_read_i = 1'b0; c0_m_wr_i = 1'b0; end
        @(negedge clk_i);
        tests++;
        if ({grant_o, m_read_o, m_wr_o} !== 4'b0000) begin
            fails++; $display("FAIL release_idle: got %b expected 0000", {grant_o, m_read_o, m_wr_o});
        end
    endtask

    task automatic serve(input int lat, input logic [DATA_W-1:0] rdata);
        bit   ok;
        txn_t e;
        wait_grant(ok, e);
        if (ok) respond(e, lat, rdata);
    endtask

    task automatic test_reset();
        reset_ni = 1'b0;
        c0_m_read_i = 1'b1;
        m_read_done_i = 1'b1;
        #3;
        tests++;
        if ({m_read_o, m_wr_o, grant_o, timeout_err_o} !== 5'b00000) begin
            fails++; $display("FAIL reset_outputs: got %b expected 00000",
                              {m_read_o, m_wr_o, grant_o, timeout_err_o});
        end
        tests++;
        if ({c0_m_busywait_o, c1_m_busywait_o, c0_m_read_done_o, c1_m_read_done_o} !== 4'b1000) begin
            fails++; $display("FAIL reset_cache_side: got %b expected 1000",
                {c0_m_busywait_o, c1_m_busywait_o, c0_m_read_done_o, c1_m_read_done_o});
        end
        c0_m_read_i = 1'b0;
        m_read_done_i = 1'b0;
        apply_reset();
    endtask

    task automatic test_single_read();
        c0_m_address_i = 28'h0000010;
        c0_m_read_i    = 1'b1;
        push_exp(2'b01, 1'b1, 1'b0, 28'h0000010, '0);
        @(negedge clk_i);
        tests++;
        if ({grant_o, c0_m_busywait_o} !== 3'b001) begin
            fails++; $display("FAIL idle_request: got %b expected 001", {grant_o, c0_m_busywait_o});
        end
        // Done lands in the 4th GRANT cycle, the same cycle the watchdog would expire.
        serve(3, pat_a);
        @(negedge clk_i);
        tests++;
        if ({grant_o, m_read_o, timeout_err_o} !== 4'b0000) begin
            fails++; $display("FAIL back_to_idle: got %b expected 0000", {grant_o, m_read_o, timeout_err_o});
        end
    endtask

    task automatic test_tie_rr();
        apply_reset();
        c0_m_address_i = 28'h0000100; c0_m_read_i = 1'b1;
        c1_m_address_i = 28'h0000200; c1_m_write_data_i = pat_b; c1_m_wr_i = 1'b1;
        push_exp(2'b01, 1'b1, 1'b0, 28'h0000100, '0);
        push_exp(2'b10, 1'b0, 1'b1, 28'h0000200, pat_b);
        serve(2, pat_a);
        serve(1, '0);
        c0_m_address_i = 28'h0000300; c0_m_read_i = 1'b1;
        c1_m_address_i = 28'h0000400; c1_m_read_i = 1'b1;
        push_exp(2'b01, 1'b1, 1'b0, 28'h0000300, '0);
        push_exp(2'b10, 1'b1, 1'b0, 28'h0000400, '0);
        serve(1, pat_b);
        serve(2, pat_a);
    endtask

    task automatic test_rd_wr_c1();
        c1_m_address_i = 28'h0ABCDE0; c1_m_write_data_i = pat_a;
        c1_m_read_i = 1'b1; c1_m_wr_i = 1'b1;
        push_exp(2'b10, 1'b0, 1'b1, 28'h0ABCDE0, pat_a);
        serve(2, '0);
    endtask

    task automatic test_abandon();
        bit   ok;
        txn_t e;
        c1_m_address_i = 28'h0000055; c1_m_read_i = 1'b1;
        push_exp(2'b10, 1'b1, 1'b0, 28'h0000055, '0);
        wait_grant(ok, e);
        c1_m_read_i = 1'b0;
        @(negedge clk_i);
        tests++;
        if ({grant_o, m_read_o, timeout_err_o} !== 4'b0000) begin
            fails++; $display("FAIL abandon_release: got %b expected 0000", {grant_o, m_read_o, timeout_err_o});
        end
        @(negedge clk_i);
    endtask

    task automatic test_watchdog();
        bit   ok;
        txn_t e;
        int   cnt;
        c0_m_address_i = 28'h0000777; c0_m_read_i = 1'b1;
        push_exp(2'b01, 1'b1, 1'b0, 28'h0000777, '0);
        wait_grant(ok, e);
        m_busywait_i = 1'b1;
        cnt = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            if (grant_o == 2'b01) cnt++;
            else break;
        end
        tests++;
        if (cnt !== TIMEOUT) begin
            fails++; $display("FAIL wd_cycles: got %0d expected %0d", cnt, TIMEOUT);
        end
        tests++;
        if ({timeout_err_o, m_read_o} !== 2'b10) begin
            fails++; $display("FAIL wd_abort: got %b expected 10", {timeout_err_o, m_read_o});
        end
        c0_m_read_i  = 1'b0;
        m_busywait_i = 1'b0;
        repeat (3) @(negedge clk_i);
        tests++;
        if ({timeout_err_o, grant_o} !== 3'b100) begin
            fails++; $display("FAIL wd_sticky: got %b expected 100", {timeout_err_o, grant_o});
        end
    endtask

    task automatic test_reset_mid_grant();
        bit   ok;
        txn_t e;
        c0_m_address_i = 28'h0000888; c0_m_read_i = 1'b1;
        push_exp(2'b01, 1'b1, 1'b0, 28'h0000888, '0);
        wait_grant(ok, e);
        reset_ni = 1'b0;
        #1;
        tests++;
        if ({m_read_o, grant_o, timeout_err_o, c0_m_busywait_o} !== 5'b00001) begin
            fails++; $display("FAIL reset_mid_grant: got %b expected 00001",
                              {m_read_o, grant_o, timeout_err_o, c0_m_busywait_o});
        end
        c0_m_read_i = 1'b0;
        @(posedge clk_i); #1;
        reset_ni = 1'b1;
        c0_m_address_i = 28'h0000901; c0_m_read_i = 1'b1;
        c1_m_address_i = 28'h0000902; c1_m_read_i = 1'b1;
        push_exp(2'b01, 1'b1, 1'b0, 28'h0000901, '0);
        push_exp(2'b10, 1'b1, 1'b0, 28'h0000902, '0);
        serve(1, pat_a);
        serve(1, pat_b);
    endtask

    initial begin
        pat_a = {32{4'hA}};
        pat_b = {8{16'h1234}};
        reset_ni = 1'b0;
        c0_m_read_i = 1'b0; c0_m_wr_i = 1'b0; c0_m_address_i = '0; c0_m_write_data_i = '0;
        c1_m_read_i = 1'b0; c1_m_wr_i = 1'b0; c1_m_address_i = '0; c1_m_write_data_i = '0;
        m_read_data_i = '0; m_busywait_i = 1'b0; m_read_done_i = 1'b0; m_write_done_i = 1'b0;
        test_reset();
        test_single_read();
        test_tie_rr();
        test_rd_wr_c1();
        test_abandon();
        test_watchdog();
        test_reset_mid_grant();
        tests++;
        if (exp_q.size() != 0) begin
            fails++; $display("FAIL scoreboard_left: %0d entries expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
